// File: rtl/ahblite_sram_slave.sv
// AHB-Lite slave bridging one interconnect port onto a synchronous single-port SRAM.
// Define AHBL_SRAM_WBUF_EN to add the one-entry write buffer (zero-wait writes, read merge).
module ahblite_sram_slave #(
  parameter int unsigned MEM_AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsel,
  input  logic [27:0]       haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [3:0]        hprot,
  input  logic              hmastlock,
  input  logic [31:0]       hwdata,
  output logic [31:0]       hrdata,
  output logic              hready,
  output logic              hresp,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_ERR1, S_ERR2, S_WDONE} state_t;

  state_t            state, state_nxt;
  logic              req, accept, err, read_issue;
  logic [BW-1:0]     be_in, cap_be;
  logic [MEM_AW-1:0] addr_in, cap_addr;
  logic [DW-1:0]     rdata_merged;
  logic              unused_ok;

  assign unused_ok  = ^{hburst, hprot, hmastlock};
  assign req        = hsel & htrans[1];
  assign accept     = req & hready & ~rst;
  assign read_issue = accept & ~hwrite & ~err;
  assign addr_in    = haddr[MEM_AW+1:2];

  // Illegal size, misalignment, or address beyond the SRAM window
  assign err = (hsize > 3'd2)
            || (hsize == 3'd1 && haddr[0])
            || (hsize == 3'd2 && haddr[1:0] != 2'b00)
            || ((haddr >> (MEM_AW + 2)) != 28'd0);

  always_comb begin
    be_in = '0;
    case (hsize)
      3'd0:    be_in = 4'b0001 << haddr[1:0];
      3'd1:    be_in = haddr[1] ? 4'b1100 : 4'b0011;
      3'd2:    be_in = 4'b1111;
      default: be_in = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_addr <= '0;
      cap_be   <= '0;
    end else if (accept) begin
      cap_addr <= addr_in;
      cap_be   <= be_in;
    end
  end

`ifdef AHBL_SRAM_WBUF_EN
  logic              wb_valid, stall, commit;
  logic [MEM_AW-1:0] wb_addr;
  logic [BW-1:0]     wb_be;
  logic [DW-1:0]     wb_data;

  // A read arriving while the buffer is still full must wait for the commit
  assign stall  = (state == S_WRITE) & wb_valid & req & ~hwrite & ~err;
  assign commit = wb_valid & ~read_issue;
  assign hready = (state != S_ERR1) && !(state == S_WRITE && stall);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_be    <= '0;
      wb_data  <= '0;
    end else if (state == S_WRITE && hready) begin
      wb_valid <= 1'b1;
      wb_addr  <= cap_addr;
      wb_be    <= cap_be;
      wb_data  <= hwdata;
    end else if (commit) begin
      wb_valid <= 1'b0;
    end
  end

  always_comb begin
    for (int b = 0; b < int'(BW); b++) begin
      rdata_merged[b*8 +: 8] = (wb_valid && wb_addr == cap_addr && wb_be[b])
                               ? wb_data[b*8 +: 8] : mem_rdata[b*8 +: 8];
    end
  end
`else
  assign hready       = (state != S_ERR1) && (state != S_WRITE);
  assign rdata_merged = mem_rdata;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_ERR1: state_nxt = S_ERR2;
`ifndef AHBL_SRAM_WBUF_EN
      S_WRITE: state_nxt = S_WDONE;
`endif
      default: begin
        if (hready) begin
          if (!accept)     state_nxt = S_IDLE;
          else if (err)    state_nxt = S_ERR1;
          else if (hwrite) state_nxt = S_WRITE;
          else             state_nxt = S_READ;
        end
      end
    endcase
  end

  // Read issue owns the SRAM port; otherwise the pending write goes out
  always_comb begin
    hresp     = (state == S_ERR1) || (state == S_ERR2);
    hrdata    = '0;
    mem_ce    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == S_READ) hrdata = rdata_merged;
    if (read_issue) begin
      mem_ce   = 1'b1;
      mem_addr = addr_in;
      mem_be   = be_in;
    end
`ifdef AHBL_SRAM_WBUF_EN
    else if (commit) begin
      mem_ce    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = wb_addr;
      mem_be    = wb_be;
      mem_wdata = wb_data;
    end
`else
    else if (state == S_WRITE) begin
      mem_ce    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = cap_addr;
      mem_be    = cap_be;
      mem_wdata = hwdata;
    end
`endif
  end
endmodule

// File: doc/ahblite_sram_slave.md
# ahblite_sram_slave

AHB-Lite responder that attaches one synchronous single-port SRAM to one slave port of the SoC AHB-Lite interconnect. It decodes the address and data phases and generates byte-lane writes from `hsize` and `haddr`. It drives `hready`, `hresp` and `hrdata` back to the interconnect. An optional one-entry write buffer gives zero-wait-state writes and back-to-back write-then-read transfers.

## Interface
- `MEM_AW`, 12: SRAM word-address width; the SRAM holds 2^MEM_AW 32-bit words.
- `clk` in 1: bus and SRAM clock.
- `rst` in 1: asynchronous, active-high reset.
- `hsel` in 1: slave select from the interconnect.
- `haddr` in 28: byte address, slave-local.
- `htrans` in 2: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `hwrite` in 1: 1 = write.
- `hsize` in 3: transfer size; 0 = byte, 1 = half, 2 = word.
- `hburst` in 3: ignored; each beat is decoded on its own.
- `hprot` in 4: ignored.
- `hmastlock` in 1: ignored.
- `hwdata` in 32: write data, valid in the data phase.
- `hrdata` out 32: read data.
- `hready` out 1: transfer done / slave ready.
- `hresp` out 1: 0 = OKAY, 1 = ERROR.
- `mem_ce` out 1: SRAM chip enable.
- `mem_we` out 1: SRAM write enable.
- `mem_be` out 4: SRAM byte enables.
- `mem_addr` out MEM_AW: SRAM word address.
- `mem_wdata` out 32: SRAM write data.
- `mem_rdata` in 32: SRAM read data, valid the cycle after `mem_ce`=1 with `mem_we`=0.

## Operation
- **Address-phase acceptance:** an address phase is accepted when `hsel`=1, `htrans[1]`=1 and `hready`=1. BUSY and IDLE transfers get an OKAY response with no wait and no SRAM access.
- **Captured at acceptance:** word address `haddr[MEM_AW+1:2]`, `hwrite`, and byte enables.
  - size 0: `be` = 1 << `haddr[1:0]`.
  - size 1: `be` = 3 << {`haddr[1]`,0}.
  - size 2: `be` = 4'hF.
- **Error conditions:** any of the following gives an ERROR response and no SRAM access.
  - `hsize`>2.
  - Misaligned address: size 1 with `haddr[0]`=1, or size 2 with `haddr[1:0]`≠0.
  - Any bit of `haddr[27:MEM_AW+2]` set.
- **FSM states:** IDLE, READ, WRITE, ERR1, ERR2.
  - Accepted read → READ.
  - Accepted write → WRITE.
  - Accepted error → ERR1.
  - ERR1 → ERR2 unconditionally.
  - The state at the end of each data phase follows from the address phase accepted in that same cycle.
- **ERROR response:** two cycles.
  - ERR1: `hready`=0, `hresp`=1.
  - ERR2: `hready`=1, `hresp`=1.
  - Address phases offered during ERR1 are not accepted.
- **Read:**
  - In the accept cycle, `mem_ce`=1, `mem_we`=0, `mem_addr` is taken combinationally from `haddr`.
  - READ is zero-wait and `hrdata` = `mem_rdata`, merged per byte with the write buffer when the buffer is valid and its address matches.
  - `hrdata`=0 in every cycle that is not a READ data phase.
- **Reset:** asynchronous; any in-flight transfer and any buffered write are discarded.

## Timing
- **Reset values:**
  - `hready`=1, `hresp`=0, `hrdata`=0.
  - `mem_ce`=0, `mem_we`=0, `mem_be`=0, `mem_addr`=0, `mem_wdata`=0.
  - FSM in IDLE; write buffer invalid.
- **Read latency:** data is returned in the first data-phase cycle (zero wait).
- **SRAM port priority:** an accepted read address phase has priority over a buffer commit. A commit only occurs in cycles where no read is being issued.
- **Simultaneous events:** a write data phase can coincide with a read address phase. With the buffer valid, this cycle stalls (`hready`=0) and commits the buffer. The next cycle captures the new write and issues the read.

## Configuration
- **`AHBL_SRAM_WBUF_EN` defined:** one-entry write buffer (address, `be`, data, valid).
  - WRITE is zero-wait; `hwdata` is captured into the buffer at the end of the data phase.
  - The buffer commits (`mem_ce`=1, `mem_we`=1) in the first cycle with no read issue, then clears valid.
  - A read that hits a pending buffered word returns the buffered bytes.
- **`AHBL_SRAM_WBUF_EN` undefined:** no buffer.
  - WRITE always takes one wait state.
  - Cycle 1: `hready`=0; `mem_we`=1 with `mem_wdata`=`hwdata` and the captured `be`.
  - Cycle 2: `hready`=1 with no SRAM access.
  - There is no read merge.

## Test plan
- **Word write then read:** write 0xDEADBEEF to 0x0000010, then read 0x0000010 → `hrdata`=0xDEADBEEF with `hresp`=0. With WBUF there are no wait states; without WBUF the write has exactly one wait state.
- **Byte merge:** write byte 0x5A at 0x0000013 after word 0x11223344 at 0x0000010, then read the word → 0x5A223344. The back-to-back write→read with WBUF also exercises the buffer-merge path.
- **Misaligned access:** word access at 0x0000002 → ERR1 (`hready`=0, `hresp`=1), then ERR2 (`hready`=1, `hresp`=1), with `mem_ce`=0 throughout.
- **Out-of-range access:** MEM_AW=12, access at 0x0004000 → two-cycle ERROR response; the SRAM contents are unchanged.
- **Stall path (WBUF):** W(0x20), W(0x24), R(0x20) back to back → exactly one stall cycle during W(0x24)'s data phase; the read returns W(0x20)'s data.
- **Reset mid-transfer:** assert `rst` during a write data phase → all outputs return to their reset values the same cycle; a subsequent read of that address returns the prior contents.
